cond_chain_arbiter: RTL and testbench



---
 rtl/cond_chain_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cond_chain_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_chain_arbiter.sv
// cond_chain_arbiter: registered one-hot grant to one of N_REQ requesters.
// The winner is chosen like an if / else-if chain: lowest index first
// (priority and unique modes) or first set bit at or above a rotating
// pointer (round-robin mode). A grant is held until the owner releases it or
// withdraws its request. Unique mode flags requests that overlap when a grant
// is decided and keeps a saturating count of those events.
module cond_chain_arbiter #(
    parameter int N_REQ = 4,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     release_i,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     viol,
    output logic [CNT_W-1:0]         viol_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    // Any MODE value other than 1 or 2 falls back to priority.
    typedef enum logic [1:0] {
        MODE_PRIO   = 2'd0,
        MODE_UNIQUE = 2'd1,
        MODE_RR     = 2'd2
    } mode_e;

    localparam mode_e EFF_MODE = (MODE == 1) ? MODE_UNIQUE :
                                 (MODE == 2) ? MODE_RR     : MODE_PRIO;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W:0]   N_EXT   = (IDX_W + 1)'(N_REQ);

    // Registered state and outputs
    state_e           state_q,     state_d;
    logic [N_REQ-1:0] gnt_q,       gnt_d;
    logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             viol_q,      viol_d;
    logic [CNT_W-1:0] viol_cnt_q,  viol_cnt_d;
    logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;

    // Selection results
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             multi_hit;

    // (base + off) mod N_REQ for base, off < N_REQ; one extra bit holds the
    // carry so a single conditional subtract is enough for any N_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(
        input logic [IDX_W-1:0] base,
        input logic [IDX_W-1:0] off
    );
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Lowest set request bit: scan downward so the last hit is the lowest.
    always_comb begin : lowest_sel
        lo_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
            end
        end
    end

    // First set request bit at or above rr_ptr, wrapping past N_REQ-1 to 0.
    always_comb begin : rr_sel
        rr_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_add(rr_ptr_q, IDX_W'(i))]) begin
                rr_idx = wrap_add(rr_ptr_q, IDX_W'(i));
            end
        end
    end

    // More than one request line is active (clearing the lowest set bit
    // leaves something behind).
    assign multi_hit = |(req & (req - REQ_ONE));
    assign sel_idx   = (EFF_MODE == MODE_RR) ? rr_idx : lo_idx;

    // Next-state and next-output logic for the IDLE/GRANT handshake.
    always_comb begin : fsm_comb
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        viol_d      = 1'b0;
        viol_cnt_d  = viol_cnt_q;
        rr_ptr_d    = rr_ptr_q;

        case (state_q)
            ST_IDLE: begin
                // release_i is ignored here; any request starts a grant.
                if (|req) begin
                    state_d     = ST_GRANT;
                    gnt_d       = REQ_ONE << sel_idx;
                    gnt_idx_d   = sel_idx;
                    gnt_valid_d = 1'b1;

                    if ((EFF_MODE == MODE_UNIQUE) && multi_hit) begin
                        viol_d = 1'b1;
                        if (viol_cnt_q != CNT_MAX) begin
                            viol_cnt_d = viol_cnt_q + CNT_ONE;
                        end
                    end

                    if (EFF_MODE == MODE_RR) begin
                        rr_ptr_d = wrap_add(sel_idx, IDX_W'(1));
                    end
                end
            end

            ST_GRANT: begin
                // Only the owner's own request bit is watched; all other
                // request changes are invisible until the next IDLE cycle.
                if (release_i || !req[gnt_idx_q]) begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State, output and pointer registers; all clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            viol_q      <= 1'b0;
            viol_cnt_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            viol_q      <= viol_d;
            viol_cnt_q  <= viol_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign viol      = viol_q;
    assign viol_cnt  = viol_cnt_q;

endmodule

// File: tb/tb_cond_chain_arbiter.sv
// Testbench for cond_chain_arbiter: four instances (priority, unique,
// unique with a 2-bit counter, round-robin) driven by directed sequences.
// Expected outputs are queued when stimulus is applied and compared one
// cycle later, after the rising edge.
module tb_cond_chain_arbiter;

    typedef enum int {D_PRIO, D_UNIQ, D_SAT, D_RR} dut_e;

    typedef struct {
        dut_e       dut;
        string      tag;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       viol;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [3:0] req_p, req_u, req_s, req_r;
    logic       rel_p, rel_u, rel_s, rel_r;

    logic [3:0] gnt_p, gnt_u, gnt_s, gnt_r;
    logic       gv_p,  gv_u,  gv_s,  gv_r;
    logic [1:0] idx_p, idx_u, idx_s, idx_r;
    logic       viol_p, viol_u, viol_s, viol_r;
    logic [7:0] cnt_p, cnt_u, cnt_r;
    logic [1:0] cnt_s;

    exp_t sb[$];
    int   n_total;
    int   n_bad;

    cond_chain_arbiter #(.N_REQ(4), .MODE(0), .CNT_W(8)) u_prio (
        .clk(clk), .rst_n(rst_n), .req(req_p), .release_i(rel_p),
        .gnt(gnt_p), .gnt_valid(gv_p), .gnt_idx(idx_p),
        .viol(viol_p), .viol_cnt(cnt_p)
    );

    cond_chain_arbiter #(.N_REQ(4), .MODE(1), .CNT_W(8)) u_uniq (
        .clk(clk), .rst_n(rst_n), .req(req_u), .release_i(rel_u),
        .gnt(gnt_u), .gnt_valid(gv_u), .gnt_idx(idx_u),
        .viol(viol_u), .viol_cnt(cnt_u)
    );

    cond_chain_arbiter #(.N_REQ(4), .MODE(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .req(req_s), .release_i(rel_s),
        .gnt(gnt_s), .gnt_valid(gv_s), .gnt_idx(idx_s),
        .viol(viol_s), .viol_cnt(cnt_s)
    );

    cond_chain_arbiter #(.N_REQ(4), .MODE(2), .CNT_W(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_r), .release_i(rel_r),
        .gnt(gnt_r), .gnt_valid(gv_r), .gnt_idx(idx_r),
        .viol(viol_r), .viol_cnt(cnt_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when the values differ.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Queues the outputs one instance must show after the coming edge.
    task automatic push_exp(input dut_e d, input string tag, input logic [3:0] g,
                            input logic [1:0] x, input logic vi, input logic [7:0] c);
        exp_t e;
        e.dut  = d;
        e.tag  = tag;
        e.gnt  = g;
        e.idx  = x;
        e.viol = vi;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    // Advances one clock, then compares every queued expectation.
    task automatic step();
        exp_t       e;
        logic [3:0] g;
        logic       v;
        logic [1:0] x;
        logic       vi;
        logic [7:0] c;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                D_PRIO:  begin g = gnt_p; v = gv_p; x = idx_p; vi = viol_p; c = cnt_p; end
                D_UNIQ:  begin g = gnt_u; v = gv_u; x = idx_u; vi = viol_u; c = cnt_u; end
                D_SAT:   begin g = gnt_s; v = gv_s; x = idx_s; vi = viol_s; c = {6'b0, cnt_s}; end
                default: begin g = gnt_r; v = gv_r; x = idx_r; vi = viol_r; c = cnt_r; end
            endcase
            check({e.tag, ".gnt"},   32'(g),  32'(e.gnt));
            check({e.tag, ".valid"}, 32'(v),  32'(|e.gnt));
            check({e.tag, ".idx"},   32'(x),  32'(e.idx));
            check({e.tag, ".viol"},  32'(vi), 32'(e.viol));
            check({e.tag, ".cnt"},   32'(c),  32'(e.cnt));
        end
    endtask

    initial begin
        logic [3:0] oh;
        logic [7:0] cnt_exp;

        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        req_p = '0; req_u = '0; req_s = '0; req_r = '0;
        rel_p = 1'b0; rel_u = 1'b0; rel_s = 1'b0; rel_r = 1'b0;

        // Reset state
        #2;
        check("rst.gnt",   32'(gnt_p), 32'(0));
        check("rst.valid", 32'(gv_p),  32'(0));
        check("rst.idx",   32'(idx_p), 32'(0));
        check("rst.viol",  32'(viol_u), 32'(0));
        check("rst.cnt",   32'(cnt_u), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Priority: grant idx 2, then asynchronous reset mid-grant
        req_p = 4'b0100;
        push_exp(D_PRIO, "p.pre_rst", 4'b0100, 2'd2, 1'b0, 8'd0);
        step();
        rst_n = 1'b0;
        #1;
        check("arst.gnt",   32'(gnt_p), 32'(0));
        check("arst.valid", 32'(gv_p),  32'(0));
        check("arst.idx",   32'(idx_p), 32'(0));
        check("arst.cnt",   32'(cnt_p), 32'(0));
        #1;
        rst_n = 1'b1;
        req_p = 4'b0001;
        push_exp(D_PRIO, "p.post_rst", 4'b0001, 2'd0, 1'b0, 8'd0);
        step();
        rel_p = 1'b1; req_p = 4'b0000;
        push_exp(D_PRIO, "p.post_rst_rel", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();
        rel_p = 1'b0;

        // Priority: req 1010 picks idx 1 and holds it
        req_p = 4'b1010;
        push_exp(D_PRIO, "p.grant", 4'b0010, 2'd1, 1'b0, 8'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            push_exp(D_PRIO, "p.hold", 4'b0010, 2'd1, 1'b0, 8'd0);
            step();
        end
        rel_p = 1'b1;
        push_exp(D_PRIO, "p.release", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();
        rel_p = 1'b0;
        push_exp(D_PRIO, "p.regrant", 4'b0010, 2'd1, 1'b0, 8'd0);
        step();
        rel_p = 1'b1; req_p = 4'b0000;
        push_exp(D_PRIO, "p.release2", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();

        // Priority: release_i high in IDLE does not block a new grant
        req_p = 4'b0010;
        push_exp(D_PRIO, "p.idle_rel", 4'b0010, 2'd1, 1'b0, 8'd0);
        step();
        push_exp(D_PRIO, "p.idle_rel_end", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();
        rel_p = 1'b0; req_p = 4'b0000;
        push_exp(D_PRIO, "p.idle", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();

        // Priority: withdrawal of the owner while another request waits
        req_p = 4'b0100;
        push_exp(D_PRIO, "w.grant", 4'b0100, 2'd2, 1'b0, 8'd0);
        step();
        req_p = 4'b0101;
        push_exp(D_PRIO, "w.other_req", 4'b0100, 2'd2, 1'b0, 8'd0);
        step();
        req_p = 4'b0001;
        push_exp(D_PRIO, "w.withdraw", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();
        push_exp(D_PRIO, "w.next", 4'b0001, 2'd0, 1'b0, 8'd0);
        step();
        rel_p = 1'b1; req_p = 4'b0000;
        push_exp(D_PRIO, "w.release", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();
        rel_p = 1'b0;

        // Unique: overlap flags once, single request does not
        req_u = 4'b0110;
        push_exp(D_UNIQ, "u.overlap", 4'b0010, 2'd1, 1'b1, 8'd1);
        step();
        push_exp(D_UNIQ, "u.pulse_end", 4'b0010, 2'd1, 1'b0, 8'd1);
        step();
        rel_u = 1'b1; req_u = 4'b0000;
        push_exp(D_UNIQ, "u.release", 4'b0000, 2'd0, 1'b0, 8'd1);
        step();
        rel_u = 1'b0; req_u = 4'b1000;
        push_exp(D_UNIQ, "u.single", 4'b1000, 2'd3, 1'b0, 8'd1);
        step();
        rel_u = 1'b1; req_u = 4'b0000;
        push_exp(D_UNIQ, "u.release2", 4'b0000, 2'd0, 1'b0, 8'd1);
        step();
        rel_u = 1'b0;

        // Unique with a 2-bit counter: saturates at 3, pulse continues
        for (int k = 0; k < 5; k++) begin
            cnt_exp = (k < 3) ? 8'(k + 1) : 8'd3;
            req_s = 4'b0011; rel_s = 1'b0;
            push_exp(D_SAT, "sat.grant", 4'b0001, 2'd0, 1'b1, cnt_exp);
            step();
            req_s = 4'b0000; rel_s = 1'b1;
            push_exp(D_SAT, "sat.release", 4'b0000, 2'd0, 1'b0, cnt_exp);
            step();
        end
        rel_s = 1'b0;

        // Round-robin: all requesting, pointer rotates 0,1,2,3,0
        req_r = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            rel_r = 1'b0;
            push_exp(D_RR, "rr.seq", oh, 2'(k % 4), 1'b0, 8'd0);
            step();
            rel_r = 1'b1;
            push_exp(D_RR, "rr.release", 4'b0000, 2'd0, 1'b0, 8'd0);
            step();
        end
        // Pointer is 1 now: scan 1,2,3 finds 3, then wraps to 0
        req_r = 4'b1001; rel_r = 1'b0;
        push_exp(D_RR, "rr.wrap3", 4'b1000, 2'd3, 1'b0, 8'd0);
        step();
        rel_r = 1'b1;
        push_exp(D_RR, "rr.release3", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();
        rel_r = 1'b0;
        push_exp(D_RR, "rr.wrap0", 4'b0001, 2'd0, 1'b0, 8'd0);
        step();
        rel_r = 1'b1; req_r = 4'b0000;
        push_exp(D_RR, "rr.release0", 4'b0000, 2'd0, 1'b0, 8'd0);
        step();
        rel_r = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
